// File: rtl/wb_regfile_stage.sv
// RV32I write-back stage: selects the WB source, extends load data, owns x1..x31,
// serves two write-through read ports, a last-write bypass record and a retire counter.
module wb_regfile_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int CNTW  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            werf_contrl,
  input  logic [1:0]      wb_contrl,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [2:0]      load_funct3,
  input  logic [1:0]      load_addr_lo,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] imm_u,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic            fwd_valid,
  output logic [AW-1:0]   fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic [CNTW-1:0] retired_cnt
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_IMMU = 2'b11
  } wb_src_e;

  logic [XLEN-1:0] r_regs [NREGS];
  logic            r_fwd_valid;
  logic [AW-1:0]   r_fwd_rd;
  logic [XLEN-1:0] r_fwd_data;
  logic [CNTW-1:0] r_retired_cnt;

  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_ext_load;
  logic [XLEN-1:0] w_wb_data;
  logic            w_commit;

  always_comb begin
    w_byte = '0;
    case (load_addr_lo)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    // addr_lo=11 falls into the upper half: misaligned halfwords are not trapped
    w_half = load_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    w_ext_load = mem_rdata;
    case (load_funct3)
      3'b000:  w_ext_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_ext_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_ext_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_ext_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_ext_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_wb_data = alu_result;
    case (wb_src_e'(wb_contrl))
      WB_ALU:  w_wb_data = alu_result;
      WB_LOAD: w_wb_data = w_ext_load;
      WB_PC4:  w_wb_data = pc_plus4;
      WB_IMMU: w_wb_data = imm_u;
      default: w_wb_data = alu_result;
    endcase
  end

  assign w_commit = werf_contrl && (wb_rd != '0);
  assign wb_data  = w_wb_data;

  // Entry 0 is cleared by reset and never written, so it stays a constant zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[wb_rd] <= w_wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fwd_valid   <= 1'b0;
      r_fwd_rd      <= '0;
      r_fwd_data    <= '0;
      r_retired_cnt <= '0;
    end else if (w_commit) begin
      r_fwd_valid   <= 1'b1;
      r_fwd_rd      <= wb_rd;
      r_fwd_data    <= w_wb_data;
      r_retired_cnt <= r_retired_cnt + CNTW'(1);
    end else begin
      r_fwd_valid   <= 1'b0;
    end
  end

  always_comb begin
    rs1_data = r_regs[rs1_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (werf_contrl && (wb_rd == rs1_addr)) begin
      rs1_data = w_wb_data;
    end
  end

  always_comb begin
    rs2_data = r_regs[rs2_addr];
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (werf_contrl && (wb_rd == rs2_addr)) begin
      rs2_data = w_wb_data;
    end
  end

  assign fwd_valid   = r_fwd_valid;
  assign fwd_rd      = r_fwd_rd;
  assign fwd_data    = r_fwd_data;
  assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Bench for wb_regfile_stage: directed vectors, a behavioural reference model checked
// every falling edge, and literal expectations pinning the model.
module tb_wb_regfile_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        werf_contrl;
  logic [1:0]  wb_contrl;
  logic [4:0]  wb_rd;
  logic [31:0] alu_result, mem_rdata, pc_plus4, imm_u;
  logic [2:0]  load_funct3;
  logic [1:0]  load_addr_lo;
  logic [4:0]  rs1_addr, rs2_addr;

  logic [31:0] rs1_data, rs2_data, wb_data, fwd_data, retired_cnt;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;

  logic [31:0] c4_rs1_data, c4_rs2_data, c4_wb_data, c4_fwd_data;
  logic        c4_fwd_valid;
  logic [4:0]  c4_fwd_rd;
  logic [3:0]  c4_retired_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_regfile_stage dut (
    .clk(clk), .reset(reset), .werf_contrl(werf_contrl), .wb_contrl(wb_contrl),
    .wb_rd(wb_rd), .alu_result(alu_result), .mem_rdata(mem_rdata),
    .load_funct3(load_funct3), .load_addr_lo(load_addr_lo), .pc_plus4(pc_plus4),
    .imm_u(imm_u), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retired_cnt(retired_cnt)
  );

  // Narrow counter instance makes the wrap-to-zero reachable by real commits
  wb_regfile_stage #(.CNTW(4)) u_dut_c4 (
    .clk(clk), .reset(reset), .werf_contrl(werf_contrl), .wb_contrl(wb_contrl),
    .wb_rd(wb_rd), .alu_result(alu_result), .mem_rdata(mem_rdata),
    .load_funct3(load_funct3), .load_addr_lo(load_addr_lo), .pc_plus4(pc_plus4),
    .imm_u(imm_u), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(c4_rs1_data), .rs2_data(c4_rs2_data), .wb_data(c4_wb_data),
    .fwd_valid(c4_fwd_valid), .fwd_rd(c4_fwd_rd), .fwd_data(c4_fwd_data),
    .retired_cnt(c4_retired_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic [31:0] m_regs [32];
  logic        m_fwd_valid;
  logic [4:0]  m_fwd_rd;
  logic [31:0] m_fwd_data;
  logic [31:0] m_cnt;

  function automatic logic [31:0] m_wb();
    logic [31:0] b, h, ext;
    b = (mem_rdata >> (8 * load_addr_lo)) & 32'hFF;
    h = (mem_rdata >> (16 * (load_addr_lo / 2))) & 32'hFFFF;
    case (load_funct3)
      3'd0:    ext = (b >= 128) ? b - 256 : b;
      3'd4:    ext = b;
      3'd1:    ext = (h >= 32768) ? h - 65536 : h;
      3'd5:    ext = h;
      default: ext = mem_rdata;
    endcase
    case (wb_contrl)
      2'd0:    return alu_result;
      2'd1:    return ext;
      2'd2:    return pc_plus4;
      default: return imm_u;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (werf_contrl && wb_rd == a) return m_wb();
    return m_regs[a];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_fwd_valid <= 1'b0;
      m_fwd_rd    <= 5'd0;
      m_fwd_data  <= 32'd0;
      m_cnt       <= 32'd0;
    end else if (werf_contrl && wb_rd != 0) begin
      m_regs[wb_rd] <= m_wb();
      m_fwd_valid   <= 1'b1;
      m_fwd_rd      <= wb_rd;
      m_fwd_data    <= m_wb();
      m_cnt         <= m_cnt + 1;
    end else begin
      m_fwd_valid   <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("wb_data",     wb_data,     m_wb());
    chk("rs1_data",    rs1_data,    m_read(rs1_addr));
    chk("rs2_data",    rs2_data,    m_read(rs2_addr));
    chk("fwd_valid",   {31'd0, fwd_valid}, {31'd0, m_fwd_valid});
    chk("fwd_rd",      {27'd0, fwd_rd},    {27'd0, m_fwd_rd});
    chk("fwd_data",    fwd_data,    m_fwd_data);
    chk("retired_cnt", retired_cnt, m_cnt);
    chk("c4_rs1_data", c4_rs1_data, m_read(rs1_addr));
    chk("c4_wb_data",  c4_wb_data,  m_wb());
    chk("c4_fwd",      {c4_fwd_valid, c4_fwd_rd, c4_fwd_data[25:0]},
                       {m_fwd_valid, m_fwd_rd, m_fwd_data[25:0]});
    chk("c4_rs2_hi",   {c4_rs2_data[31:26], 26'd0}, {m_read(rs2_addr) >> 26, 26'd0});
    chk("c4_retired",  {28'd0, c4_retired_cnt}, {28'd0, m_cnt[3:0]});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [2:0]  t_f3  [14] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd0, 3'd4, 3'd1, 3'd5, 3'd1, 3'd3, 3'd6, 3'd7};
  logic [1:0]  t_lo  [14] = '{2'd0, 2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0, 2'd2, 2'd3};
  logic [31:0] t_exp [14] = '{32'h0000007F, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8081,
                              32'h0000F27F, 32'h8081F27F, 32'hFFFFFFF2, 32'h00000081,
                              32'hFFFF8081, 32'h00008081, 32'hFFFFF27F, 32'h8081F27F,
                              32'h8081F27F, 32'h8081F27F};

  initial begin
    reset = 1'b0; werf_contrl = 1'b0; wb_contrl = 2'd0; wb_rd = 5'd0;
    alu_result = '0; mem_rdata = '0; pc_plus4 = '0; imm_u = '0;
    load_funct3 = 3'd0; load_addr_lo = 2'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("lit_rst_cnt", retired_cnt, 32'd0);
    chk("lit_rst_fwdv", {31'd0, fwd_valid}, 32'd0);

    // Link write with same-cycle read-through on both ports
    werf_contrl = 1'b1; wb_rd = 5'd7; wb_contrl = 2'b10; pc_plus4 = 32'h104;
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1 chk("lit_wt_rs1", rs1_data, 32'h104);
    chk("lit_wt_rs2", rs2_data, 32'h104);
    @(posedge clk); #1 werf_contrl = 1'b0;
    chk("lit_fwdv", {31'd0, fwd_valid}, 32'd1);
    chk("lit_fwdrd", {27'd0, fwd_rd}, 32'd7);
    chk("lit_fwddata", fwd_data, 32'h104);
    #1 chk("lit_x7", rs1_data, 32'h104);
    chk("lit_cnt1", retired_cnt, 32'd1);

    // Write to x0 is ignored
    werf_contrl = 1'b1; wb_rd = 5'd0; wb_contrl = 2'b00; alu_result = 32'h1234;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1 chk("lit_x0_rd", rs1_data, 32'd0);
    chk("lit_x0_wb", wb_data, 32'h1234);
    @(posedge clk); #1 werf_contrl = 1'b0;
    chk("lit_x0_fwdv", {31'd0, fwd_valid}, 32'd0);
    chk("lit_x0_cnt", retired_cnt, 32'd1);
    chk("lit_x0_fwdrd", {27'd0, fwd_rd}, 32'd7);

    // LUI source with write disabled
    wb_contrl = 2'b11; imm_u = 32'hABCD0000; wb_rd = 5'd9; rs1_addr = 5'd9;
    #1 chk("lit_immu", wb_data, 32'hABCD0000);
    chk("lit_x9_pre", rs1_data, 32'd0);
    @(posedge clk); #1
    chk("lit_x9_post", rs1_data, 32'd0);
    chk("lit_x9_fwdv", {31'd0, fwd_valid}, 32'd0);

    // Load extension table
    wb_contrl = 2'b01; mem_rdata = 32'h8081F27F;
    for (int i = 0; i < 14; i++) begin
      load_funct3 = t_f3[i]; load_addr_lo = t_lo[i];
      #1 chk($sformatf("lit_load%0d", i), wb_data, t_exp[i]);
    end
    werf_contrl = 1'b1; wb_rd = 5'd3; load_funct3 = 3'd0; load_addr_lo = 2'd3;
    @(posedge clk); #1 werf_contrl = 1'b0; rs2_addr = 5'd3;
    #1 chk("lit_x3_lb", rs2_data, 32'hFFFFFF80);

    // Mixed traffic, checked by the model
    for (int i = 0; i < 20; i++) begin
      werf_contrl  = (i % 4) != 3;
      wb_rd        = 5'((i * 7 + 1) % 32);
      wb_contrl    = 2'(i % 4);
      alu_result   = 32'h1000_0000 + 32'(i) * 32'h111;
      mem_rdata    = {mem_rdata[26:0], mem_rdata[31:27]} ^ 32'(i);
      pc_plus4     = 32'h200 + 32'(4 * i);
      imm_u        = 32'(i) << 12;
      load_funct3  = 3'(i % 8);
      load_addr_lo = 2'(i % 4);
      rs1_addr     = wb_rd;
      rs2_addr     = 5'((i * 3) % 32);
      @(posedge clk); #1;
    end

    // Reset mid-cycle with a write in flight
    werf_contrl = 1'b1; wb_contrl = 2'b00; alu_result = 32'hDEADBEEF; wb_rd = 5'd5;
    rs1_addr = 5'd5;
    @(posedge clk); #1 werf_contrl = 1'b0;
    #1 chk("lit_x5", rs1_data, 32'hDEADBEEF);
    werf_contrl = 1'b1; alu_result = 32'hCAFEF00D;
    #1 reset = 1'b1;
    #1 chk("lit_rst_cnt2", retired_cnt, 32'd0);
    chk("lit_rst_fwdv2", {31'd0, fwd_valid}, 32'd0);
    chk("lit_rst_fwdd2", fwd_data, 32'd0);
    werf_contrl = 1'b0;
    #1 chk("lit_rst_x5", rs1_data, 32'd0);
    werf_contrl = 1'b1;
    @(posedge clk); #1 werf_contrl = 1'b0;
    #1 chk("lit_rst_x5b", rs1_data, 32'd0);
    reset = 1'b0;
    #1 chk("lit_rst_x5c", rs1_data, 32'd0);

    // Sixteen commits: narrow counter wraps to zero
    for (int i = 0; i < 16; i++) begin
      werf_contrl = 1'b1; wb_contrl = 2'b00; wb_rd = 5'((i % 31) + 1);
      alu_result = 32'(i); rs1_addr = 5'd1; rs2_addr = 5'd16;
      @(posedge clk); #1;
    end
    werf_contrl = 1'b0;
    chk("lit_wrap_c4", {28'd0, c4_retired_cnt}, 32'd0);
    chk("lit_cnt16", retired_cnt, 32'd16);

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
